sonar_ranger: RTL

- Ultrasonic ranging front end that sits directly upstream of the processor's io_pins/data input path.
- Fires a trigger pulse to the sonar module and times the returned echo pulse in clock cycles.
- Publishes the result with a sticky valid/ack handshake so processor software can poll it.
- Also drives the 8-bit io_pins status byte the processor reads.

---
 rtl/sonar_pkg.sv | 30 +++
 rtl/sonar_ranger_if.sv | 26 ++
 rtl/sonar_ranger_sync_edge.sv | 21 ++
 rtl/sonar_ranger.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar ranging front end.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  // Bit positions inside the io_pins status byte; bits 1:0 read as zero.
  localparam int IO_VALID   = 7;
  localparam int IO_TIMEOUT = 6;
  localparam int IO_OVERRUN = 5;
  localparam int IO_BUSY    = 4;
  localparam int IO_TRIG    = 3;
  localparam int IO_ECHO    = 2;

  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_TIMEOUT_CYCLES = 1500000;
  localparam int DEF_HOLDOFF_CYCLES = 3000000;
  localparam int DEF_COUNT_W        = 24;

  // Bits needed to count 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sonar_ranger_if.sv
// Control/status bundle between the sonar ranger and the processor io path.
interface sonar_ranger_if #(
  parameter int COUNT_W = sonar_pkg::DEF_COUNT_W
);
  logic               start;
  logic               auto_en;
  logic               echo;
  logic               result_ack;
  logic               trig;
  logic               busy;
  logic               result_valid;
  logic               timeout;
  logic               overrun;
  logic [COUNT_W-1:0] echo_cycles;
  logic [7:0]         io_pins;

  modport master (
    output start, auto_en, echo, result_ack,
    input  trig, busy, result_valid, timeout, overrun, echo_cycles, io_pins
  );

  modport slave (
    input  start, auto_en, echo, result_ack,
    output trig, busy, result_valid, timeout, overrun, echo_cycles, io_pins
  );
endinterface

// File: rtl/sonar_ranger_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synced level.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // pipe[1] is the synced level, pipe[2] its previous value for edge detect.
  logic [2:0] pipe;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pipe <= '0;
    else        pipe <= {pipe[1:0], d};
  end

  assign q    = pipe[1];
  assign rise = pipe[1] & ~pipe[2];
  assign fall = ~pipe[1] & pipe[2];
endmodule

// File: rtl/sonar_ranger.sv
// Sonar trigger/echo timer with sticky valid/ack result and io_pins status byte.
module sonar_ranger
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int COUNT_W        = DEF_COUNT_W
) (
  input  logic          clock,
  input  logic          reset,
  sonar_ranger_if.slave bus
);
  localparam int PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int PH_W   = cnt_w(PH_MAX);
  localparam logic [PH_W-1:0]    TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]    HOLD_LAST = PH_W'(HOLDOFF_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TO_LAST   = COUNT_W'(TIMEOUT_CYCLES - 1);
  localparam longint CNT_LIM = (longint'(1) << COUNT_W) - 1;
  localparam bit     TO_OK   = longint'(TIMEOUT_CYCLES) < CNT_LIM;

  state_t             state;
  logic [PH_W-1:0]    ph_cnt;
  logic [COUNT_W-1:0] to_cnt;
  logic [COUNT_W-1:0] width;
  logic               trig_q, busy_q;
  logic               valid_q, timeout_q, overrun_q;
  logic [COUNT_W-1:0] cycles_q;
  logic               echo_s, echo_rise, echo_fall;
  logic               commit, commit_to;
  logic [7:0]         io;

  sync_edge u_echo (
    .clock (clock),
    .reset (reset),
    .d     (bus.echo),
    .q     (echo_s),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  // A rise in WAIT_RISE or a fall in MEASURE beats a coincident timeout.
  always_comb begin
    commit    = 1'b0;
    commit_to = 1'b0;
    case (state)
      WAIT_RISE: if (!echo_rise && to_cnt >= TO_LAST) begin
        commit    = 1'b1;
        commit_to = 1'b1;
      end
      MEASURE: begin
        if (echo_fall) commit = 1'b1;
        else if (to_cnt >= TO_LAST) begin
          commit    = 1'b1;
          commit_to = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ph_cnt <= '0;
      to_cnt <= '0;
      width  <= '0;
      trig_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start || bus.auto_en) begin
          state  <= TRIG;
          trig_q <= 1'b1;
          busy_q <= 1'b1;
          ph_cnt <= '0;
        end
        TRIG: begin
          if (ph_cnt == TRIG_LAST) begin
            state  <= WAIT_RISE;
            trig_q <= 1'b0;
            to_cnt <= '0;
          end else ph_cnt <= ph_cnt + 1'b1;
        end
        WAIT_RISE: begin
          to_cnt <= to_cnt + 1'b1;
          if (echo_rise) begin
            state <= MEASURE;
            width <= COUNT_W'(1);
          end else if (commit) begin
            state  <= HOLDOFF;
            ph_cnt <= '0;
          end
        end
        MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          if (commit) begin
            state  <= HOLDOFF;
            ph_cnt <= '0;
          end else width <= width + 1'b1;
        end
        HOLDOFF: begin
          if (ph_cnt == HOLD_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else ph_cnt <= ph_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit beats ack; a same-cycle ack still covers the prior result's overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      cycles_q  <= '0;
    end else if (commit) begin
      valid_q   <= 1'b1;
      timeout_q <= commit_to;
      overrun_q <= valid_q & ~bus.result_ack;
      cycles_q  <= commit_to ? '1 : width;
    end else if (bus.result_ack) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  always_comb begin
    io             = '0;
    io[IO_VALID]   = valid_q;
    io[IO_TIMEOUT] = timeout_q;
    io[IO_OVERRUN] = overrun_q;
    io[IO_BUSY]    = busy_q;
    io[IO_TRIG]    = trig_q;
    io[IO_ECHO]    = echo_s;
  end

  assign bus.trig         = trig_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.overrun      = overrun_q;
  assign bus.echo_cycles  = cycles_q;
  assign bus.io_pins      = io;

  to_fits_count_w: assert property (@(posedge clock) TO_OK);
endmodule
